// File: rtl/cpu_sequencer.sv
// cpu_sequencer: phase sequencer and Avalon-style bus master for the
// multi-cycle MIPS core. It walks FETCH -> EXEC1 -> EXEC2 for each instruction.
// FETCH reads the instruction word, EXEC1 carries the optional load/store,
// and EXEC2 returns load data. Every bus phase stalls on waitrequest.
module cpu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_address,
    input  logic        halt,
    input  logic        mem_read_req,
    input  logic        mem_write_req,
    input  logic [31:0] data_address,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    output logic        fetch,
    output logic        exec1,
    output logic        exec2,
    output logic [31:0] instr,
    output logic [31:0] load_data,
    output logic        active
);

    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_EXEC1  = 3'd2;
    localparam logic [2:0] S_EXEC2  = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [31:0] r_instr;
    logic [31:0] r_load_data;
    logic        r_first;      // current EXEC1 cycle is the first one
    logic        r_rd_issued;  // the EXEC1 just finished was a load

    logic        w_rd;
    logic        w_wr;
    logic        w_req;

    // A load outranks a store when the decoder raises both
    assign w_rd  = mem_read_req;
    assign w_wr  = mem_write_req & ~mem_read_req;
    assign w_req = w_rd | w_wr;

    // Next-state logic; waitrequest only matters while a bus request is live
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RESET:  w_next_state = S_FETCH;
            S_FETCH:  w_next_state = waitrequest ? S_FETCH : S_EXEC1;
            S_EXEC1:  w_next_state = (w_req && waitrequest) ? S_EXEC1 : S_EXEC2;
            S_EXEC2:  w_next_state = halt ? S_HALTED : S_FETCH;
            S_HALTED: w_next_state = S_HALTED;
            default:  w_next_state = S_RESET;
        endcase
    end

    // State register; reset abandons any in-flight bus request immediately
    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= S_RESET;
        else
            r_state <= w_next_state;
    end

    // Instruction/load capture and the bookkeeping flags behind them
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_instr     <= 32'd0;
            r_load_data <= 32'd0;
            r_first     <= 1'b0;
            r_rd_issued <= 1'b0;
        end else begin
            case (r_state)
                S_RESET: begin
                    r_instr     <= 32'd0;
                    r_load_data <= 32'd0;
                    r_first     <= 1'b0;
                    r_rd_issued <= 1'b0;
                end
                S_FETCH: begin
                    // The fetch data arrives in the cycle after acceptance,
                    // i.e. the first EXEC1 cycle
                    r_first <= 1'b1;
                end
                S_EXEC1: begin
                    if (r_first)
                        r_instr <= readdata;
                    r_first     <= 1'b0;
                    r_rd_issued <= w_rd;
                end
                S_EXEC2: begin
                    if (r_rd_issued)
                        r_load_data <= readdata;
                    r_rd_issued <= 1'b0;
                end
                default: begin
                    r_first     <= 1'b0;
                    r_rd_issued <= 1'b0;
                end
            endcase
        end
    end

    // Output decode: strobes, bus drive and the pass-through data views
    always_comb begin
        address    = 32'd0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = 32'd0;
        byteenable = 4'd0;
        fetch      = 1'b0;
        exec1      = 1'b0;
        exec2      = 1'b0;
        active     = 1'b0;
        instr      = r_instr;
        load_data  = r_load_data;
        case (r_state)
            S_RESET: begin
                instr     = 32'd0;
                load_data = 32'd0;
            end
            S_FETCH: begin
                fetch      = 1'b1;
                active     = 1'b1;
                read       = 1'b1;
                address    = pc_address;
                byteenable = 4'b1111;
            end
            S_EXEC1: begin
                exec1  = 1'b1;
                active = 1'b1;
                // The decoder sees the fresh word before it is registered
                if (r_first)
                    instr = readdata;
                if (w_rd) begin
                    read       = 1'b1;
                    address    = data_address;
                    byteenable = data_byteenable;
                end else if (w_wr) begin
                    write      = 1'b1;
                    address    = data_address;
                    writedata  = data_writedata;
                    byteenable = data_byteenable;
                end
            end
            S_EXEC2: begin
                exec2  = 1'b1;
                active = 1'b1;
                if (r_rd_issued)
                    load_data = readdata;
            end
            default: begin
                // HALTED: bus idle, registers keep their last values
            end
        endcase
    end

    // At most one phase strobe, and only while running
    always_ff @(posedge clk) begin
        assert ($onehot0({fetch, exec1, exec2}));
        assert (!active || $onehot({fetch, exec1, exec2}));
    end

endmodule
